// File: rtl/shot_trigger.sv
// Flick-gesture shot trigger: tracks per-axis peaks, presents one scaled shot.
// Optional SHOT_TRIGGER_AUTOARM_EN: cooldown expiry rearms instead of idling.
module shot_trigger #(
    parameter logic [15:0] THRESH      = 16'd400,
    parameter logic [15:0] RELEASE     = 16'd200,
    parameter int          MIN_SAMPLES = 4,
    parameter int          MAX_SAMPLES = 64,
    parameter int          COOLDOWN    = 256,
    parameter int          SHIFT       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] x_mag,
    input  logic [15:0] y_mag,
    input  logic        arm,
    output logic        shot_valid,
    input  logic        shot_ready,
    output logic [7:0]  shot_vx,
    output logic [7:0]  shot_vy,
    output logic        busy,
    output logic [2:0]  state
);

    localparam int CW  = $clog2(MAX_SAMPLES + 1);
    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_TRACK    = 3'd2,
        S_PRESENT  = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

`ifdef SHOT_TRIGGER_AUTOARM_EN
    localparam state_t REARM = S_ARMED;
`else
    localparam state_t REARM = S_IDLE;
`endif

    state_t          state_q, state_d;
    logic [15:0]     peak_x_q, peak_x_d;
    logic [15:0]     peak_y_q, peak_y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CDW-1:0]  cd_q, cd_d;
    logic [7:0]      vx_q, vx_d;
    logic [7:0]      vy_q, vy_d;
    logic            valid_q, valid_d;

    logic [15:0]     m;
    logic [15:0]     px_max;
    logic [15:0]     py_max;
    logic [CW-1:0]   cnt_inc;

    function automatic logic [7:0] sat8(input logic [15:0] p);
        logic [15:0] s;
        s = p >> SHIFT;
        return (|s[15:8]) ? 8'hFF : s[7:0];
    endfunction

    assign m       = (x_mag > y_mag) ? x_mag : y_mag;
    assign px_max  = (peak_x_q > x_mag) ? peak_x_q : x_mag;
    assign py_max  = (peak_y_q > y_mag) ? peak_y_q : y_mag;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        peak_x_d = peak_x_q;
        peak_y_d = peak_y_q;
        cnt_d    = cnt_q;
        cd_d     = cd_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        valid_d  = valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (sample_valid && m >= THRESH) begin
                    state_d  = S_TRACK;
                    peak_x_d = x_mag;
                    peak_y_d = y_mag;
                    cnt_d    = CW'(1);
                end
            end
            S_TRACK: begin
                if (sample_valid) begin
                    if (m < RELEASE) begin
                        if (cnt_q >= CW'(MIN_SAMPLES)) begin
                            state_d = S_PRESENT;
                            vx_d    = sat8(peak_x_q);
                            vy_d    = sat8(peak_y_q);
                            valid_d = 1'b1;
                        end else begin
                            // Too short to be a flick: drop it silently.
                            state_d  = S_ARMED;
                            peak_x_d = '0;
                            peak_y_d = '0;
                            cnt_d    = '0;
                        end
                    end else begin
                        peak_x_d = px_max;
                        peak_y_d = py_max;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == CW'(MAX_SAMPLES)) begin
                            state_d = S_PRESENT;
                            vx_d    = sat8(px_max);
                            vy_d    = sat8(py_max);
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            S_PRESENT: begin
                if (shot_ready) begin
                    valid_d  = 1'b0;
                    peak_x_d = '0;
                    peak_y_d = '0;
                    cnt_d    = '0;
                    if (COOLDOWN == 0) begin
                        state_d = REARM;
                    end else begin
                        state_d = S_COOLDOWN;
                        cd_d    = CDW'(COOLDOWN);
                    end
                end
            end
            S_COOLDOWN: begin
                if (sample_valid) begin
                    if (cd_q <= CDW'(1)) begin
                        cd_d    = '0;
                        state_d = REARM;
                    end else begin
                        cd_d = cd_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            peak_x_q <= '0;
            peak_y_q <= '0;
            cnt_q    <= '0;
            cd_q     <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            peak_x_q <= peak_x_d;
            peak_y_q <= peak_y_d;
            cnt_q    <= cnt_d;
            cd_q     <= cd_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            valid_q  <= valid_d;
        end
    end

    assign shot_valid = valid_q;
    assign shot_vx    = vx_q;
    assign shot_vy    = vy_q;
    assign state      = state_q;
    assign busy       = (state_q == S_TRACK) || (state_q == S_PRESENT)
                     || (state_q == S_COOLDOWN);

endmodule

// File: tb/tb_shot_trigger.sv
// Directed bench for shot_trigger with immediate-assertion checks.
// Rearm target follows SHOT_TRIGGER_AUTOARM_EN.
module tb_shot_trigger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] x_mag = '0;
    logic [15:0] y_mag = '0;
    logic        arm = 1'b0;
    logic        shot_valid;
    logic        shot_ready = 1'b1;
    logic [7:0]  shot_vx;
    logic [7:0]  shot_vy;
    logic        busy;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail = 0;

`ifdef SHOT_TRIGGER_AUTOARM_EN
    localparam logic [2:0] REARM_ST = 3'd1;
`else
    localparam logic [2:0] REARM_ST = 3'd0;
`endif

    shot_trigger dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .x_mag        (x_mag),
        .y_mag        (y_mag),
        .arm          (arm),
        .shot_valid   (shot_valid),
        .shot_ready   (shot_ready),
        .shot_vx      (shot_vx),
        .shot_vy      (shot_vy),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sv, input logic [15:0] x,
                        input logic [15:0] y, input logic a);
        sample_valid = sv;
        x_mag = x;
        y_mag = y;
        arm = a;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        arm = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st,
                           input logic v, input logic [7:0] vx,
                           input logic [7:0] vy);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".valid"}, 32'(shot_valid), 32'(v));
        chk({tag, ".vx"}, 32'(shot_vx), 32'(vx));
        chk({tag, ".vy"}, 32'(shot_vy), 32'(vy));
    endtask

    task automatic cooldown(input string tag);
        for (int i = 0; i < 255; i++) step(1'b1, 16'd1000, 16'd1000, 1'b0);
        chk({tag, ".cd255"}, 32'(state), 32'd4);
        step(1'b1, 16'd1000, 16'd1000, 1'b0);
        chk({tag, ".cd256"}, 32'(state), 32'(REARM_ST));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        chk_out("reset", 3'd0, 1'b0, 8'd0, 8'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 16'd1000, 16'd1000, 1'b0);
        chk("idle.sample", 32'(state), 32'd0);
        step(1'b1, 16'd1000, 16'd0, 1'b1);
        chk("idle.arm_with_sample", 32'(state), 32'd1);

        // Nominal shot
        step(1'b1, 16'd100, 16'd50, 1'b0);
        chk("nom.below", 32'(state), 32'd1);
        step(1'b1, 16'd500, 16'd100, 1'b0);
        chk("nom.track", 32'(state), 32'd2);
        chk("nom.busy", 32'(busy), 32'd1);
        step(1'b1, 16'd900, 16'd300, 1'b0);
        step(1'b1, 16'd1200, 16'd600, 1'b0);
        step(1'b1, 16'd800, 16'd400, 1'b0);
        step(1'b1, 16'd300, 16'd100, 1'b0);
        chk_out("nom.tracking", 3'd2, 1'b0, 8'd0, 8'd0);
        step(1'b1, 16'd150, 16'd50, 1'b0);
        chk_out("nom.present", 3'd3, 1'b1, 8'd75, 8'd37);
        step(1'b0, 16'd0, 16'd0, 1'b0);
        chk_out("nom.handshake", 3'd4, 1'b0, 8'd75, 8'd37);
        cooldown("nom");
        step(1'b0, 16'd0, 16'd0, 1'b1);
        chk("nom.rearm", 32'(state), 32'd1);

        // Glitch reject
        step(1'b1, 16'd500, 16'd0, 1'b0);
        step(1'b1, 16'd600, 16'd0, 1'b0);
        chk("glitch.track", 32'(state), 32'd2);
        step(1'b1, 16'd100, 16'd0, 1'b0);
        chk_out("glitch.reject", 3'd1, 1'b0, 8'd75, 8'd37);

        // Threshold boundaries with backpressure
        shot_ready = 1'b0;
        step(1'b1, 16'd399, 16'd0, 1'b0);
        chk("bnd.below_thresh", 32'(state), 32'd1);
        step(1'b1, 16'd400, 16'd399, 1'b0);
        chk("bnd.at_thresh", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 16'd200, 16'd0, 1'b0);
        chk("bnd.at_release", 32'(state), 32'd2);
        step(1'b1, 16'd199, 16'd0, 1'b0);
        chk_out("bnd.present", 3'd3, 1'b1, 8'd25, 8'd24);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'd1000, 16'd1000, 1'b0);
            chk_out("bp.hold", 3'd3, 1'b1, 8'd25, 8'd24);
        end
        shot_ready = 1'b1;
        step(1'b0, 16'd0, 16'd0, 1'b0);
        chk_out("bp.handshake", 3'd4, 1'b0, 8'd25, 8'd24);
        cooldown("bp");
        step(1'b0, 16'd0, 16'd0, 1'b1);

        // Saturation, forced end, reset during PRESENT
        shot_ready = 1'b0;
        for (int i = 0; i < 63; i++) step(1'b1, 16'd8000, 16'd1000, 1'b0);
        chk("sat.63", 32'(state), 32'd2);
        step(1'b1, 16'd8000, 16'd1000, 1'b0);
        chk_out("sat.present", 3'd3, 1'b1, 8'd255, 8'd62);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("sat.reset", 3'd0, 1'b0, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        shot_ready = 1'b1;

        // Reset mid-TRACK
        step(1'b0, 16'd0, 16'd0, 1'b1);
        step(1'b1, 16'd1000, 16'd1000, 1'b0);
        chk("trk.track", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("trk.reset", 3'd0, 1'b0, 8'd0, 8'd0);
        chk("trk.busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 16'd1000, 16'd1000, 1'b0);
        chk("trk.idle_sample", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_trigger.md
# shot_trigger

Downstream consumer of the accelerometer front-end's filtered X/Y flick magnitudes. It detects one deliberate flick gesture and tracks the per-axis peak magnitude over the gesture. It then presents one scaled launch-velocity pair (vx, vy) to the ball-physics stage over a valid/ready handshake. After a launch it enforces a cooldown so that one physical flick yields exactly one shot.

## Interface
Parameters:
- THRESH, 16'd400: start threshold, compared against max(x_mag, y_mag).
- RELEASE, 16'd200: end-of-gesture threshold; must be ≤ THRESH.
- MIN_SAMPLES, 4: minimum gesture length in samples. Shorter gestures are rejected as glitches.
- MAX_SAMPLES, 64: gesture length at which a shot is forced.
- COOLDOWN, 256: number of samples ignored after a handshake.
- SHIFT, 4: right-shift applied to the peaks to form the velocities.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; x_mag/y_mag are valid in this cycle.
- x_mag  in  16  unsigned X flick magnitude.
- y_mag  in  16  unsigned Y flick magnitude.
- arm  in  1  one-cycle pulse that arms the trigger from IDLE.
- shot_valid  out  1  launch data available.
- shot_ready  in  1  consumer accepts the launch data.
- shot_vx  out  8  X launch velocity.
- shot_vy  out  8  Y launch velocity.
- busy  out  1  high in TRACK, PRESENT and COOLDOWN.
- state  out  3  current state encoding, for debug and LEDs.

## Operation
- m = max(x_mag, y_mag), unsigned compare. All sample-driven actions occur only in cycles where sample_valid=1.
- States and encodings: IDLE=0, ARMED=1, TRACK=2, PRESENT=3, COOLDOWN=4.
- IDLE:
  - arm=1 → ARMED.
  - Samples are ignored. A sample coincident with arm is not evaluated.
- ARMED:
  - A sample with m ≥ THRESH → TRACK.
  - On entry: peak_x=x_mag, peak_y=y_mag, cnt=1.
- TRACK, on each sample:
  - If m < RELEASE: go to PRESENT when cnt ≥ MIN_SAMPLES, otherwise back to ARMED with peaks discarded and no output.
  - Otherwise: peak_x=max(peak_x, x_mag), peak_y=max(peak_y, y_mag), cnt=cnt+1. If the new cnt == MAX_SAMPLES → PRESENT.
- Entry to PRESENT:
  - shot_vx = (peak_x>>SHIFT), saturated to 255. shot_vy is formed the same way from peak_y.
  - shot_valid=1.
- PRESENT:
  - shot_vx/shot_vy/shot_valid are held stable until shot_valid&shot_ready at a clk edge. Samples are ignored.
  - On the handshake: shot_valid=0, cooldown counter loaded with COOLDOWN, → COOLDOWN.
- COOLDOWN:
  - Each sample decrements the counter. When the counter reaches 0 → rearm target (see Configuration).
- arm outside IDLE is ignored.
- busy is high exactly in TRACK, PRESENT and COOLDOWN.
- Width rules:
  - cnt: $clog2(MAX_SAMPLES+1) bits, never wraps.
  - Cooldown counter: $clog2(COOLDOWN+1) bits.
  - COOLDOWN=0 leaves the state on the handshake edge directly to the rearm target.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0.
  - shot_valid=0, shot_vx=0, shot_vy=0.
  - All peaks and counters cleared.
- Reset asserted mid-gesture or during PRESENT drops shot_valid immediately. No partial shot survives.
- All state transitions are registered on the clk edge that samples the qualifying input.
- shot_valid rises on the clk edge of the sample that ends TRACK, i.e. 1 cycle latency from that sample.
- shot_vx/shot_vy are valid in the same cycle that shot_valid rises.
- shot_ready may be high before shot_valid. The handshake completes on the first edge where both are 1, so the minimum PRESENT duration is 1 cycle.
- shot_vx/shot_vy retain their last value after the handshake. Only shot_valid qualifies them.
- A sample arriving in the same cycle as a TRACK→PRESENT transition is the terminating sample. There is no double counting.

## Configuration
- SHOT_TRIGGER_AUTOARM_EN defined: COOLDOWN expiry → ARMED, giving continuous play without further arm pulses.
- SHOT_TRIGGER_AUTOARM_EN undefined: COOLDOWN expiry → IDLE, and a new arm pulse is required before the next shot.
- The macro changes no other behaviour or port.

## Test plan
All scenarios use the default parameters, with shot_ready=1 unless stated.

- **Reset and idle:** pulse rst_n low mid-TRACK → immediately state=0, busy=0, shot_valid=0, shot_vx=shot_vy=0. Samples in IDLE with m=1000 → no state change.
- **Nominal shot:** arm, then samples x=100,500,900,1200,800,300,150 with y=50,100,300,600,400,100,50.
  - TRACK is entered on x=500, and cnt=5 at release.
  - shot_valid pulses one cycle after the 150 sample, with shot_vx=75 and shot_vy=37.
- **Glitch reject:** arm, then x=500,600,100 with y=0 → returns to ARMED, shot_valid never asserts, peaks discarded.
- **Saturation and forced end:** arm, then 64 samples of x=8000, y=1000.
  - PRESENT is entered on the 64th sample.
  - shot_vx=255 (8000>>4=500, saturated), shot_vy=62.
- **Backpressure:** nominal shot with shot_ready=0 for 10 cycles while samples of m=1000 keep arriving.
  - shot_valid, shot_vx and shot_vy stay stable and the samples are ignored.
  - Handshake on the first ready cycle, then state=4.
- **Cooldown and rearm:** after a handshake, 255 samples keep state=4. The 256th sample moves to state=1 with SHOT_TRIGGER_AUTOARM_EN defined, or to state=0 without it.
